// File: rtl/aabb_seq_unit.sv
// aabb_seq_unit: converts an oriented box or a sphere into an axis-aligned bounding box,
// time-multiplexing one single-precision multiplier and one adder over stb/ack handshakes.
package aabb_fp_pkg;
  typedef enum logic [1:0] {C_GET, C_CALC, C_PUT} core_st_t;
  function automatic logic is_nan(input logic [31:0] a);
    return (&a[30:23]) && (|a[22:0]);
  endfunction
  function automatic logic is_inf(input logic [31:0] a);
    return (&a[30:23]) && !(|a[22:0]);
  endfunction
  function automatic int exp_of(input logic [31:0] a);
    return a[30:23] == 8'd0 ? 1 : int'(a[30:23]);
  endfunction
  function automatic int lzc48(input logic [47:0] m);
    lzc48 = 48;
    for (int i = 0; i < 48; i++) if (m[i]) lzc48 = 47 - i;
  endfunction
  // m is nonzero with its leading one at bit 47, worth 2^(e-127); rounds to nearest even
  function automatic logic [31:0] round_pack(input logic s, input int e, input logic [47:0] m);
    logic [47:0] v;
    logic st;
    logic [24:0] r;
    int ex;
    int sh;
    v = m;
    st = 1'b0;
    ex = e;
    sh = 1 - e;
    if (ex < 1) begin
      st = sh > 47 ? |m : |(m << (48 - sh));
      v = sh > 47 ? 48'd0 : m >> sh;
      ex = 0;
    end
    st = st | (|v[22:0]);
    r = {1'b0, v[47:24]} + {24'd0, v[23] & (st | v[24])};
    if (r[24]) begin
      r = r >> 1;
      ex = ex + 1;
    end
    if (ex == 0 && r[23]) ex = 1;
    return ex > 254 ? {s, 8'hff, 23'd0} : {s, ex[7:0], r[22:0]};
  endfunction
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic s;
    logic [47:0] p;
    int lz;
    s = a[31] ^ b[31];
    p = {24'd0, a[30:23] != 8'd0, a[22:0]} * {24'd0, b[30:23] != 8'd0, b[22:0]};
    lz = lzc48(p);
    if (is_nan(a) || is_nan(b) || (is_inf(a) && b[30:0] == 31'd0) || (is_inf(b) && a[30:0] == 31'd0))
      return 32'h7fc00000;
    if (is_inf(a) || is_inf(b)) return {s, 8'hff, 23'd0};
    if (p == 48'd0) return {s, 31'd0};
    return round_pack(s, exp_of(a) + exp_of(b) - 126 - lz, p << lz);
  endfunction
  // smaller operand is aligned with a jammed sticky bit below 23 guard bits
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x;
    logic [31:0] y;
    logic [47:0] mx;
    logic [47:0] my;
    logic [47:0] sm;
    int d;
    int lz;
    x = a[30:0] >= b[30:0] ? a : b;
    y = a[30:0] >= b[30:0] ? b : a;
    d = exp_of(x) - exp_of(y);
    mx = {1'b0, x[30:23] != 8'd0, x[22:0], 23'd0};
    my = {1'b0, y[30:23] != 8'd0, y[22:0], 23'd0};
    my = d > 47 ? {47'd0, |my} : (my >> d) | {47'd0, |(my << (48 - d))};
    sm = x[31] == y[31] ? mx + my : mx - my;
    lz = lzc48(sm);
    if (is_nan(a) || is_nan(b) || (is_inf(a) && is_inf(b) && a[31] != b[31])) return 32'h7fc00000;
    if (is_inf(x)) return x;
    if (sm == 48'd0) return {a[31] & b[31], 31'd0};
    return round_pack(x[31], exp_of(x) + 1 - lz, sm << lz);
  endfunction
endpackage

module aabb_fp_core #(
  parameter bit ADD = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  input  logic [31:0] input_b,
  input  logic        input_b_stb,
  output logic        input_b_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);
  import aabb_fp_pkg::*;
  core_st_t st;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] z;
  if (ADD) begin : g_add
    assign z = fp_add(a, b);
  end else begin : g_mul
    assign z = fp_mul(a, b);
  end
  assign input_a_ack = st == C_GET;
  assign input_b_ack = st == C_GET;
  assign output_z_stb = st == C_PUT;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= C_GET;
      a <= '0;
      b <= '0;
      output_z <= '0;
    end else begin
      case (st)
        C_GET: if (input_a_stb && input_b_stb) begin
          a <= input_a;
          b <= input_b;
          st <= C_CALC;
        end
        C_CALC: begin
          output_z <= z;
          st <= C_PUT;
        end
        default: if (output_z_ack) st <= C_GET;
      endcase
    end
endmodule

module aabb_seq_unit #(
  parameter int          TAG_W  = 4,
  parameter logic [31:0] MARGIN = 32'h00000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             mode,
  input  logic [31:0]      x,
  input  logic [31:0]      y,
  input  logic [31:0]      z,
  input  logic [31:0]      side0,
  input  logic [31:0]      side1,
  input  logic [31:0]      side2,
  input  logic [31:0]      r0,
  input  logic [31:0]      r1,
  input  logic [31:0]      r2,
  input  logic [31:0]      r4,
  input  logic [31:0]      r5,
  input  logic [31:0]      r6,
  input  logic [31:0]      r8,
  input  logic [31:0]      r9,
  input  logic [31:0]      r10,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic [31:0]      aabb0,
  output logic [31:0]      aabb1,
  output logic [31:0]      aabb2,
  output logic [31:0]      aabb3,
  output logic [31:0]      aabb4,
  output logic [31:0]      aabb5,
  output logic             busy
);
  typedef enum logic [2:0] {IDLE, MUL, ACC, HALF, MARG, LO, HI, OUT} state_t;
  state_t state, state_n;
  logic [1:0] ax, j;
  logic issued, mode_q;
  logic [TAG_W-1:0] tag_q;
  logic [31:0] cen_q [3];
  logic [31:0] side_q [3];
  logic [31:0] t_q [3];
  logic [31:0] rot_q [3][3];
  logic [31:0] res_q [6];
  logic [31:0] sum_q, rng_q;
  logic [31:0] mul_a, mul_b, mul_z, add_a, add_b, add_z;
  logic mul_stb, mul_a_ack, mul_b_ack, mul_z_stb, mul_ack;
  logic add_stb, add_a_ack, add_b_ack, add_z_stb, add_ack;
  logic use_mul, use_add;
  assign in_ready = state == IDLE && !rst;
  assign out_valid = state == OUT;
  assign busy = state != IDLE;
  assign {aabb0, aabb1, aabb2, aabb3, aabb4, aabb5} = {res_q[0], res_q[1], res_q[2], res_q[3], res_q[4], res_q[5]};
  assign use_mul = state == MUL;
  assign use_add = state inside {ACC, MARG, LO, HI};
  // stb is raised until the core takes the operands; ack is one cycle on the result
  assign mul_stb = use_mul && !issued;
  assign add_stb = use_add && !issued;
  assign mul_ack = use_mul && issued && mul_z_stb;
  assign add_ack = use_add && issued && add_z_stb;
  assign mul_a = rot_q[ax][j];
  assign mul_b = side_q[j];
  assign add_a = state == ACC ? (j == 2'd0 ? t_q[0] : sum_q) : state == MARG ? rng_q : cen_q[ax];
  assign add_b = state == ACC ? (j == 2'd0 ? t_q[1] : t_q[2]) : state == MARG ? MARGIN :
                 state == LO ? {~rng_q[31], rng_q[30:0]} : rng_q;
  aabb_fp_core #(.ADD(1'b0)) u_mul (
    .clk(clk), .rst(rst),
    .input_a(mul_a), .input_a_stb(mul_stb), .input_a_ack(mul_a_ack),
    .input_b(mul_b), .input_b_stb(mul_stb), .input_b_ack(mul_b_ack),
    .output_z(mul_z), .output_z_stb(mul_z_stb), .output_z_ack(mul_ack)
  );
  aabb_fp_core #(.ADD(1'b1)) u_add (
    .clk(clk), .rst(rst),
    .input_a(add_a), .input_a_stb(add_stb), .input_a_ack(add_a_ack),
    .input_b(add_b), .input_b_stb(add_stb), .input_b_ack(add_b_ack),
    .output_z(add_z), .output_z_stb(add_z_stb), .output_z_ack(add_ack)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (in_valid && in_ready) state_n = mode ? HALF : MUL;
      MUL: if (mul_ack && j == 2'd2) state_n = ACC;
      ACC: if (add_ack && j == 2'd1) state_n = HALF;
      HALF: state_n = MARGIN == 32'd0 ? LO : MARG;
      MARG: if (add_ack) state_n = LO;
      LO: if (add_ack) state_n = HI;
      HI: if (add_ack) state_n = ax == 2'd2 ? OUT : mode_q ? HALF : MUL;
      default: if (out_ready) state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      issued <= 1'b0;
      ax <= '0;
      j <= '0;
      mode_q <= 1'b0;
      tag_q <= '0;
      out_tag <= '0;
      sum_q <= '0;
      rng_q <= '0;
      for (int i = 0; i < 3; i++) begin
        cen_q[i] <= '0;
        side_q[i] <= '0;
        t_q[i] <= '0;
        for (int k = 0; k < 3; k++) rot_q[i][k] <= '0;
      end
      for (int i = 0; i < 6; i++) res_q[i] <= '0;
    end else begin
      state <= state_n;
      issued <= (issued || (mul_stb && mul_a_ack && mul_b_ack) || (add_stb && add_a_ack && add_b_ack))
                && !(mul_ack || add_ack);
      case (state)
        IDLE: if (in_valid) begin
          mode_q <= mode;
          tag_q <= in_tag;
          cen_q <= '{x, y, z};
          side_q <= '{side0, side1, side2};
          rot_q <= '{'{r0, r1, r2}, '{r4, r5, r6}, '{r8, r9, r10}};
          ax <= '0;
          j <= '0;
        end
        MUL: if (mul_ack) begin
          t_q[j] <= {1'b0, mul_z[30:0]};
          j <= j == 2'd2 ? 2'd0 : j + 2'd1;
        end
        ACC: if (add_ack) begin
          sum_q <= add_z;
          j <= j == 2'd1 ? 2'd0 : j + 2'd1;
        end
        // sphere takes |radius| directly, which equals halving the doubled extent
        HALF: rng_q <= mode_q ? (side_q[0][30:23] == 8'd0 ? 32'd0 : {1'b0, side_q[0][30:0]})
                              : (sum_q[30:23] == 8'd0 ? 32'd0 : {sum_q[31], sum_q[30:23] - 8'd1, sum_q[22:0]});
        MARG: if (add_ack) rng_q <= add_z;
        LO: if (add_ack) res_q[{ax, 1'b0}] <= add_z;
        HI: if (add_ack) begin
          res_q[{ax, 1'b1}] <= add_z;
          ax <= ax + 2'd1;
          if (ax == 2'd2) out_tag <= tag_q;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_aabb_seq_unit.sv
// tb_aabb_seq_unit: directed vectors against hand-computed bounding boxes, with and without margin.
module tb_aabb_seq_unit;
  localparam logic [287:0] ROT_ID = {32'h3F800000, 32'h0, 32'h0, 32'h0, 32'h3F800000, 32'h0, 32'h0, 32'h0, 32'h3F800000};
  localparam logic [287:0] ROT_Z  = {32'h0, 32'hBF800000, 32'h0, 32'h3F800000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h3F800000};
  localparam logic [287:0] ROT_JUNK = {9{32'h41234567}};
  localparam logic [191:0] E_ID = {32'h0, 32'h40000000, 32'h0, 32'h40800000, 32'h0, 32'h40C00000};
  localparam logic [191:0] E_RZ = {32'hC0000000, 32'h40000000, 32'hBF800000, 32'h3F800000, 32'hC0400000, 32'h40400000};
  localparam logic [191:0] E_SP = {32'hBF000000, 32'h40200000, 32'h3F000000, 32'h40600000, 32'h3FC00000, 32'h40900000};
  localparam logic [191:0] E_SM = {32'hC0000000, 32'h40000000, 32'hC0000000, 32'h40000000, 32'hC0000000, 32'h40000000};
  logic clk = 1'b0;
  logic rst, go, sel, out_ready, mode;
  logic [3:0] in_tag;
  logic [31:0] x, y, z, side0, side1, side2, r0, r1, r2, r4, r5, r6, r8, r9, r10;
  logic rdy0, rdym, val0, valm, busy0, busym;
  logic [3:0] tag0, tagm;
  logic [31:0] b0 [6];
  logic [31:0] bm [6];
  logic o_rdy, o_valid, o_busy;
  logic [3:0] o_tag;
  logic [191:0] obs;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  aabb_seq_unit dut (
    .clk(clk), .rst(rst), .in_valid(go && !sel), .in_ready(rdy0), .in_tag(in_tag), .mode(mode),
    .x(x), .y(y), .z(z), .side0(side0), .side1(side1), .side2(side2),
    .r0(r0), .r1(r1), .r2(r2), .r4(r4), .r5(r5), .r6(r6), .r8(r8), .r9(r9), .r10(r10),
    .out_valid(val0), .out_ready(out_ready), .out_tag(tag0),
    .aabb0(b0[0]), .aabb1(b0[1]), .aabb2(b0[2]), .aabb3(b0[3]), .aabb4(b0[4]), .aabb5(b0[5]), .busy(busy0)
  );
  aabb_seq_unit #(.MARGIN(32'h3F000000)) dut_m (
    .clk(clk), .rst(rst), .in_valid(go && sel), .in_ready(rdym), .in_tag(in_tag), .mode(mode),
    .x(x), .y(y), .z(z), .side0(side0), .side1(side1), .side2(side2),
    .r0(r0), .r1(r1), .r2(r2), .r4(r4), .r5(r5), .r6(r6), .r8(r8), .r9(r9), .r10(r10),
    .out_valid(valm), .out_ready(out_ready), .out_tag(tagm),
    .aabb0(bm[0]), .aabb1(bm[1]), .aabb2(bm[2]), .aabb3(bm[3]), .aabb4(bm[4]), .aabb5(bm[5]), .busy(busym)
  );
  assign o_rdy = sel ? rdym : rdy0;
  assign o_valid = sel ? valm : val0;
  assign o_busy = sel ? busym : busy0;
  assign o_tag = sel ? tagm : tag0;
  assign obs = sel ? {bm[0], bm[1], bm[2], bm[3], bm[4], bm[5]} : {b0[0], b0[1], b0[2], b0[3], b0[4], b0[5]};

  task automatic set_tx(input logic m, input logic [3:0] tg, input logic [31:0] cx, input logic [31:0] cy,
                        input logic [31:0] cz, input logic [31:0] s0, input logic [31:0] s1,
                        input logic [31:0] s2, input logic [287:0] rot);
    mode = m;
    in_tag = tg;
    {x, y, z, side0, side1, side2} = {cx, cy, cz, s0, s1, s2};
    {r0, r1, r2, r4, r5, r6, r8, r9, r10} = rot;
  endtask

  task automatic accept(input logic hold);
    int n;
    n = 0;
    go = 1'b1;
    while (!o_rdy && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!o_rdy) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout in_ready=%b required=1", o_rdy);
    end
    @(posedge clk);
    #1;
    if (!hold) go = 1'b0;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!o_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!o_valid) begin
      checks++;
      failures++;
      $display("FAIL out_valid_timeout out_valid=%b required=1", o_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    go = 1'b0;
    sel = 1'b0;
    out_ready = 1'b1;
    set_tx(1'b0, 4'd0, 0, 0, 0, 0, 0, 0, '0);
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      checks++;
      if ({o_rdy, o_valid, o_busy} !== 3'b000) begin
        failures++;
        $display("FAIL reset_ctrl dut=%0d rdy/valid/busy=%b required=000", s, {o_rdy, o_valid, o_busy});
      end
      checks++;
      if (obs !== 192'd0 || o_tag !== 4'd0) begin
        failures++;
        $display("FAIL reset_data dut=%0d aabb=%h tag=%h required zero", s, obs, o_tag);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      checks++;
      if (o_rdy !== 1'b1) begin
        failures++;
        $display("FAIL reset_release dut=%0d in_ready=%b required=1", s, o_rdy);
      end
    end
    sel = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_identity();
    set_tx(1'b0, 4'd5, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40000000, 32'h40800000, 32'h40C00000, ROT_ID);
    accept(1'b0);
    checks++;
    if (o_busy !== 1'b1 || o_rdy !== 1'b0) begin
      failures++;
      $display("FAIL identity_busy busy=%b in_ready=%b required busy=1 in_ready=0", o_busy, o_rdy);
    end
    set_tx(1'b1, 4'd11, 32'hC1000000, 32'h42000000, 32'h3E000000, 32'h41000000, 32'h41000000, 32'h41000000, ROT_JUNK);
    wait_out();
    checks++;
    if (obs !== E_ID || o_tag !== 4'd5) begin
      failures++;
      $display("FAIL identity got=%h tag=%h want=%h tag=5", obs, o_tag, E_ID);
    end
    @(posedge clk);
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_rdy !== 1'b1 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL identity_xfer valid/ready/busy=%b required=010", {o_valid, o_rdy, o_busy});
    end
  endtask

  task automatic test_rot_z();
    set_tx(1'b0, 4'd6, 0, 0, 0, 32'h40000000, 32'h40800000, 32'h40C00000, ROT_Z);
    accept(1'b0);
    wait_out();
    checks++;
    if (obs !== E_RZ || o_tag !== 4'd6) begin
      failures++;
      $display("FAIL rot_z got=%h tag=%h want=%h tag=6", obs, o_tag, E_RZ);
    end
    @(negedge clk);
  endtask

  task automatic test_sphere();
    set_tx(1'b1, 4'd12, 32'h3F800000, 32'h40000000, 32'h40400000, 32'hBFC00000, 32'h7F800000, 32'h7FC00000, ROT_JUNK);
    accept(1'b0);
    wait_out();
    checks++;
    if (obs !== E_SP || o_tag !== 4'd12) begin
      failures++;
      $display("FAIL sphere got=%h tag=%h want=%h tag=c", obs, o_tag, E_SP);
    end
    @(negedge clk);
    sel = 1'b1;
    set_tx(1'b1, 4'd9, 0, 0, 0, 32'hBFC00000, 0, 0, ROT_JUNK);
    accept(1'b0);
    wait_out();
    checks++;
    if (obs !== E_SM || o_tag !== 4'd9) begin
      failures++;
      $display("FAIL sphere_margin got=%h tag=%h want=%h tag=9", obs, o_tag, E_SM);
    end
    @(negedge clk);
    sel = 1'b0;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    set_tx(1'b0, 4'd10, 0, 0, 0, 32'h40000000, 32'h40800000, 32'h40C00000, ROT_Z);
    accept(1'b0);
    wait_out();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (obs !== E_RZ || o_tag !== 4'd10 || {o_valid, o_rdy, o_busy} !== 3'b101) begin
        failures++;
        $display("FAIL backpressure cycle=%0d got=%h tag=%h v/r/b=%b want=%h tag=a v/r/b=101",
                 i, obs, o_tag, {o_valid, o_rdy, o_busy}, E_RZ);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_rdy !== 1'b1) begin
      failures++;
      $display("FAIL backpressure_release valid=%b in_ready=%b required valid=0 in_ready=1", o_valid, o_rdy);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    set_tx(1'b0, 4'd7, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40000000, 32'h40800000, 32'h40C00000, ROT_ID);
    accept(1'b0);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs !== 192'd0 || o_tag !== 4'd0 || {o_valid, o_rdy, o_busy} !== 3'b000) begin
      failures++;
      $display("FAIL reset_mid got=%h tag=%h v/r/b=%b required all zero", obs, o_tag, {o_valid, o_rdy, o_busy});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (o_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL reset_mid_ghost out_valid_cycles=%0d required=0", seen);
    end
    set_tx(1'b0, 4'd3, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40000000, 32'h40800000, 32'h40C00000, ROT_ID);
    accept(1'b0);
    wait_out();
    checks++;
    if (obs !== E_ID || o_tag !== 4'd3) begin
      failures++;
      $display("FAIL reset_mid_next got=%h tag=%h want=%h tag=3", obs, o_tag, E_ID);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    set_tx(1'b0, 4'd1, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40000000, 32'h40800000, 32'h40C00000, ROT_ID);
    accept(1'b1);
    set_tx(1'b0, 4'd2, 0, 0, 0, 32'h40000000, 32'h40800000, 32'h40C00000, ROT_Z);
    wait_out();
    checks++;
    if (obs !== E_ID || o_tag !== 4'd1) begin
      failures++;
      $display("FAIL b2b_first got=%h tag=%h want=%h tag=1", obs, o_tag, E_ID);
    end
    @(negedge clk);
    checks++;
    if (o_rdy !== 1'b1 || o_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle in_ready=%b valid=%b required in_ready=1 valid=0", o_rdy, o_valid);
    end
    @(negedge clk);
    go = 1'b0;
    checks++;
    if (o_busy !== 1'b1 || o_rdy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_accept busy=%b in_ready=%b required busy=1 in_ready=0", o_busy, o_rdy);
    end
    wait_out();
    checks++;
    if (obs !== E_RZ || o_tag !== 4'd2) begin
      failures++;
      $display("FAIL b2b_second got=%h tag=%h want=%h tag=2", obs, o_tag, E_RZ);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_identity();
    test_rot_z();
    test_sphere();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/aabb_seq_unit.md
AABB_SEQ_UNIT -- requirements
Module: aabb_seq_unit

Interface
REQ-001 SHALL have parameter TAG_W, default 4, width of the transaction tag carried from input to output.
REQ-002 SHALL have parameter MARGIN, default 32'h00000000, IEEE-754 single margin added to every half-extent; 0 disables the margin step.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 in_valid / in_ready  in / out  1  input handshake; transfer when both are high on a clk edge.
REQ-006 in_tag  in  TAG_W  transaction tag.
REQ-007 mode  in  1  0 = box, 1 = sphere.
REQ-008 x, y, z  in  32  centre, IEEE-754 single.
REQ-009 side0, side1, side2  in  32  box side lengths; in sphere mode side0 is the radius and side1/side2 are ignored.
REQ-010 r0, r1, r2, r4, r5, r6, r8, r9, r10  in  32  rotation rows 0..2, columns 0..2.
REQ-011 out_valid / out_ready  out / in  1  output handshake.
REQ-012 out_tag  out  TAG_W  tag of the result.
REQ-013 aabb0..aabb5  out  32  xmin, xmax, ymin, ymax, zmin, zmax.
REQ-014 busy  out  1  high from input acceptance until the output transfer.

Function
REQ-015 SHALL instantiate exactly one floating-point multiplier and one floating-point adder, both using the codebase stb/ack handshake, and time-multiplex them.
REQ-016 SHALL drive each core's stb high only while its operands are stable, and SHALL hold output_z_ack high for exactly one cycle per result consumed.
REQ-017 SHALL latch all inputs on acceptance; later input changes SHALL NOT affect the result.
REQ-018 FSM states: IDLE, MUL, ACC, HALF, MARG, LO, HI, OUT.
REQ-019 in_ready SHALL be high only in IDLE.
REQ-020 Box mode: for each axis a = 0..2, MUL forms |R[a][j]*side_j| for j = 0..2 in order, and ACC sums the three terms left to right.
REQ-021 Sphere mode: MUL and ACC are skipped; the extent sum is 2*|side0|, so that HALF yields |side0|.
REQ-022 Absolute value SHALL clear bit 31; negation SHALL invert bit 31.
REQ-023 HALF SHALL take one cycle and use no core: if exponent == 0 the result is +0, otherwise the exponent is decremented by 1.
REQ-024 MARG SHALL add MARGIN to the half-extent; it is skipped when MARGIN == 0.
REQ-025 LO computes centre + (-range); HI computes centre + range.
REQ-026 Axes are processed x, then y, then z; results go to aabb0/1, aabb2/3 and aabb4/5 respectively.
REQ-027 After HI of the z axis, the FSM SHALL enter OUT and assert out_valid the following cycle.
REQ-028 In OUT, aabb*, out_tag and out_valid SHALL hold stable until out_ready is high.
REQ-029 On the out_valid & out_ready edge, the FSM SHALL return to IDLE and in_ready SHALL be high the next cycle; there is no overlap between transactions.
REQ-030 Core operation counts: box 9 mul + 6 add + 6 bound adds; sphere 6 bound adds; plus 3 margin adds when MARGIN != 0.
REQ-031 Special operands (NaN, Inf, denormal) SHALL propagate exactly as the cores produce them; only HALF flushes denormals to +0.

Reset
REQ-032 While rst is high: state = IDLE; out_valid = 0; busy = 0; in_ready = 0; aabb0..5 = 0; out_tag = 0; both cores reset.
REQ-033 in_ready SHALL be high on the first cycle after rst deasserts.
REQ-034 rst asserted mid-transaction SHALL abort the transaction, and no out_valid pulse for it SHALL ever appear.

Verification
REQ-035 Box, identity R (r0 = r5 = r10 = 3F800000, others 0), sides 2, 4, 6 (40000000, 40800000, 40C00000), centre (1, 2, 3) -> aabb = 0, 2, 0, 4, 0, 6 (00000000, 40000000, 00000000, 40800000, 00000000, 40C00000).
REQ-036 Box, 90 deg about z (r1 = BF800000, r4 = 3F800000, r10 = 3F800000, others 0), sides 2, 4, 6, centre 0 -> aabb = -2, 2, -1, 1, -3, 3.
REQ-037 Sphere, side0 = BFC00000 (-1.5), centre (0, 0, 0), MARGIN = 3F000000 -> aabb = -2, 2, -2, 2, -2, 2; tag returned unchanged.
REQ-038 Backpressure: out_ready held low for 10 cycles after out_valid -> outputs and out_tag stable, in_ready low, busy high; transfer on the first out_ready high cycle.
REQ-039 Reset mid-MUL: assert rst 5 cycles after acceptance -> all outputs 0 immediately, no out_valid; next transaction (tag 3) produces correct results with out_tag = 3.
REQ-040 Back-to-back: two transactions with tags 1 and 2 and in_valid held high -> second accepted the cycle after the first output transfer; results in order.
